mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline; the producing end of the EX forwarding interface.
- Registers EX results (EX/MEM register) and performs load/store on a req/ack data-memory port.
- Aligns load data, then registers writeback values (MEM/WB register).
- Drives alu_outM/r3_addrM/RegWriteM/MemtoRegM and r3_dinW/r3_addrW/RegWriteW/MemtoRegW back to forwarding; raises stallM while memory is outstanding.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_align.sv | 82 ++++++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
/*--------------------------------------------------------------------
 * Module : mips_pkg
 * Brief  : Opcodes, widths, MEM-stage FSM encoding and opcode class helpers.
 * Rev    : 1.0  initial release
 *------------------------------------------------------------------*/
`default_nettype none

package mips_pkg;

  localparam int C_DATA_W = 32;
  localparam int C_REG_AW = 5;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [0:0] MS_IDLE = 1'b0;
  localparam logic [0:0] MS_WAIT = 1'b1;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
/*--------------------------------------------------------------------
 * Module : mem_stage_if
 * Brief  : Data-memory req/ack port; master = MEM stage, slave = memory.
 * Rev    : 1.0  initial release
 *------------------------------------------------------------------*/
`default_nettype none

interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  input  dm_ack, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  output dm_ack, dm_rdata);
endinterface

`default_nettype wire

// File: rtl/mem_stage_align.sv
/*--------------------------------------------------------------------
 * Module : mem_align
 * Brief  : Store byte-enable/lane replication and load lane select/extend.
 * Rev    : 1.0  initial release
 *------------------------------------------------------------------*/
`default_nettype none

module mem_align
  import mips_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  wire logic [5:0]  op_i,
  input  wire logic [1:0]  addr_lo_i,
  input  wire logic [31:0] st_data_i,
  input  wire logic [31:0] rd_data_i,
  output logic      [3:0]  be_o,
  output logic      [31:0] wdata_o,
  output logic      [31:0] ld_data_o
);

  logic [3:0]  w_be_le;
  logic [1:0]  w_byte_lane;
  logic [1:0]  w_half_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_be_le = 4'hF;
    wdata_o = st_data_i;
    if (is_byte(op_i)) begin
      w_be_le = 4'b0001 << addr_lo_i;
      wdata_o = {4{st_data_i[7:0]}};
    end else if (is_half(op_i)) begin
      w_be_le = 4'b0011 << addr_lo_i;
      wdata_o = {2{st_data_i[15:0]}};
    end
  end

  generate
    if (BIG_ENDIAN != 0) begin : g_big
      assign be_o        = {w_be_le[0], w_be_le[1], w_be_le[2], w_be_le[3]};
      assign w_byte_lane = ~addr_lo_i;
      assign w_half_lane = 2'd2 - addr_lo_i;
    end else begin : g_little
      assign be_o        = w_be_le;
      assign w_byte_lane = addr_lo_i;
      assign w_half_lane = addr_lo_i;
    end
  endgenerate

  // A half at lane 3 straddles the word; only its low byte exists.
  always_comb begin
    w_byte = rd_data_i[7:0];
    w_half = rd_data_i[15:0];
    case (w_byte_lane)
      2'd1:    w_byte = rd_data_i[15:8];
      2'd2:    w_byte = rd_data_i[23:16];
      2'd3:    w_byte = rd_data_i[31:24];
      default: w_byte = rd_data_i[7:0];
    endcase
    case (w_half_lane)
      2'd1:    w_half = rd_data_i[23:8];
      2'd2:    w_half = rd_data_i[31:16];
      2'd3:    w_half = {8'h00, rd_data_i[31:24]};
      default: w_half = rd_data_i[15:0];
    endcase
  end

  always_comb begin
    case (op_i)
      OP_LB:   ld_data_o = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ld_data_o = {24'h0, w_byte};
      OP_LH:   ld_data_o = {{16{w_half[15]}}, w_half};
      OP_LHU:  ld_data_o = {16'h0, w_half};
      default: ld_data_o = rd_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
/*--------------------------------------------------------------------
 * Module : mem_stage
 * Brief  : MIPS MEM stage: EX/MEM and MEM/WB registers plus req/ack memory FSM.
 *          Optional macro MEM_MISALIGN_TRAP_EN adds misaligned-access trapping.
 * Rev    : 1.0  initial release
 *------------------------------------------------------------------*/
`default_nettype none

module mem_stage
  import mips_pkg::*;
#(
  parameter int BIG_ENDIAN = 0,
  parameter int OPC_W      = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [31:0]      alu_outE,
  input  wire logic [4:0]       r3_addrE,
  input  wire logic [31:0]      r2_doutEC,
  input  wire logic [OPC_W-1:0] opE,
  input  wire logic             RegWriteE,
  input  wire logic             MemtoRegE,
  input  wire logic             MemWriteE,
  output logic      [31:0]      alu_outM,
  output logic      [4:0]       r3_addrM,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  stallM,
  mem_stage_if.master           dmem,
  output logic      [31:0]      r3_dinW,
  output logic      [4:0]       r3_addrW,
  output logic                  RegWriteW,
  output logic                  MemtoRegW
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic                exc_misalignM
`endif
);

  logic [31:0]      alu_out_m_q;
  logic [4:0]       r3_addr_m_q;
  logic             regwrite_m_q, memtoreg_m_q, memwrite_m_q;
  logic [OPC_W-1:0] op_m_q;
  logic [31:0]      r2_dout_m_q;
  logic [31:0]      r3_din_w_q;
  logic [4:0]       r3_addr_w_q;
  logic             regwrite_w_q, memtoreg_w_q;
  logic [0:0]       state_q, state_d;

  logic        w_memop, w_go, w_req, w_kill;
  logic [31:0] w_ld_data;

  // A store opcode only counts when MemWrite agrees; a stray MemWrite is ignored.
  assign w_memop = is_load(op_m_q) || (is_store(op_m_q) && memwrite_m_q);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = w_memop &&
                      ((is_half(op_m_q) && alu_out_m_q[0]) ||
                       (is_word(op_m_q) && (alu_out_m_q[1:0] != 2'b00)));
  assign w_go          = w_memop && !w_misalign;
  assign w_kill        = w_misalign;
  assign exc_misalignM = w_misalign;
`else
  assign w_go   = w_memop;
  assign w_kill = 1'b0;
`endif

  assign w_req  = w_go || (state_q == MS_WAIT);
  assign stallM = w_req && !dmem.dm_ack;

  assign dmem.dm_req  = w_req;
  assign dmem.dm_we   = w_req && is_store(op_m_q);
  assign dmem.dm_addr = {alu_out_m_q[31:2], 2'b00};

  mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op_i      (op_m_q),
    .addr_lo_i (alu_out_m_q[1:0]),
    .st_data_i (r2_dout_m_q),
    .rd_data_i (dmem.dm_rdata),
    .be_o      (dmem.dm_be),
    .wdata_o   (dmem.dm_wdata),
    .ld_data_o (w_ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (w_req && !dmem.dm_ack) state_d = MS_WAIT;
      MS_WAIT: if (dmem.dm_ack)           state_d = MS_IDLE;
      default:                            state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MS_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_m_q  <= '0;
      r3_addr_m_q  <= '0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      op_m_q       <= '0;
      r2_dout_m_q  <= '0;
    end else if (!stallM) begin
      alu_out_m_q  <= alu_outE;
      r3_addr_m_q  <= r3_addrE;
      regwrite_m_q <= RegWriteE;
      memtoreg_m_q <= MemtoRegE;
      memwrite_m_q <= MemWriteE;
      op_m_q       <= opE;
      r2_dout_m_q  <= r2_doutEC;
    end
  end

  // Stall edges inject a bubble so forwarding never sees the W value twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_din_w_q   <= '0;
      r3_addr_w_q  <= '0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
    end else if (stallM) begin
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
    end else begin
      r3_din_w_q   <= memtoreg_m_q ? w_ld_data : alu_out_m_q;
      r3_addr_w_q  <= r3_addr_m_q;
      regwrite_w_q <= regwrite_m_q && !w_kill;
      memtoreg_w_q <= memtoreg_m_q && !w_kill;
    end
  end

  assign alu_outM  = alu_out_m_q;
  assign r3_addrM  = r3_addr_m_q;
  assign RegWriteM = regwrite_m_q;
  assign MemtoRegM = memtoreg_m_q;
  assign r3_dinW   = r3_din_w_q;
  assign r3_addrW  = r3_addr_w_q;
  assign RegWriteW = regwrite_w_q;
  assign MemtoRegW = memtoreg_w_q;

endmodule

`default_nettype wire
